// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed op latency
// with a busy counter and requests D-stage stalls. Optional madd under `MDU_MADD_EN`.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_MADD  = 3'b111
  } mdu_op_e;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [4:0] MULT_LAT = MULT_CYCLES[4:0];
  localparam logic [4:0] DIV_LAT  = DIV_CYCLES[4:0];

  logic [4:0]  count, count_nxt;
  logic [31:0] a_q, a_nxt;
  logic [31:0] b_q, b_nxt;
  mdu_op_e     op_q, op_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  mdu_op_e     op_in;
  state_e      state;
  logic        start_mdu;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        div_signed, neg_q, neg_r;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
`ifdef MDU_MADD_EN
  logic [63:0] acc;
`endif

  assign op_in = mdu_op_e'(mdu_op);
  assign state = (count != '0) ? BUSY : IDLE;
  assign busy  = (state == BUSY);

  always_comb begin
    start_mdu = 1'b0;
    if (start) begin
      unique case (op_in)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_mdu = 1'b1;
`ifdef MDU_MADD_EN
        OP_MADD:                            start_mdu = 1'b1;
`endif
        default:                            start_mdu = 1'b0;
      endcase
    end
  end

  assign stall = md_use_D & (busy | start_mdu);

  // Products are taken mod 2^64, so the signed one is just the product of the
  // sign-extended operands.
  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
`ifdef MDU_MADD_EN
  assign acc    = {HI, LO} + prod_s;
`endif

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to
  // 0x80000000 rem 0; the divisor is forced nonzero since that result is discarded.
  assign div_signed = (op_q == OP_DIV);
  assign neg_q      = div_signed & (a_q[31] ^ b_q[31]);
  assign neg_r      = div_signed & a_q[31];
  assign a_mag      = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign b_mag      = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign divisor    = (b_q == '0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / divisor;
  assign r_mag      = a_mag % divisor;
  assign quot       = neg_q ? (~q_mag + 32'd1) : q_mag;
  assign rem        = neg_r ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    count_nxt = count;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    hi_nxt    = HI;
    lo_nxt    = LO;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (op_in)
            OP_MULT, OP_MULTU: begin
              a_nxt     = A;
              b_nxt     = B;
              op_nxt    = op_in;
              count_nxt = MULT_LAT;
            end
            OP_DIV, OP_DIVU: begin
              a_nxt     = A;
              b_nxt     = B;
              op_nxt    = op_in;
              count_nxt = DIV_LAT;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
              a_nxt     = A;
              b_nxt     = B;
              op_nxt    = op_in;
              count_nxt = MULT_LAT;
            end
`endif
            OP_MTHI: hi_nxt = A;
            OP_MTLO: lo_nxt = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        count_nxt = count - 5'd1;
        if (count == 5'd1) begin
          unique case (op_q)
            OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
            OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
            OP_DIV, OP_DIVU: begin
              if (b_q != '0) begin
                hi_nxt = rem;
                lo_nxt = quot;
              end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_nxt, lo_nxt} = acc;
`endif
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_NONE;
      HI    <= '0;
      LO    <= '0;
    end else begin
      count <= count_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      op_q  <= op_nxt;
      HI    <= hi_nxt;
      LO    <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO/latency queued at issue, checked at completion.
// Define MDU_MADD_EN for both files to cover madd.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A, B;
  logic        md_use_D;
  logic        busy, stall;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .md_use_D(md_use_D), .busy(busy), .stall(stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    int   n;
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
    mdu_op = OP_NONE;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_busy_cycles"}, 32'(n), 32'(e.lat));
    chk({e.tag, "_hi"}, HI, e.hi);
    chk({e.tag, "_lo"}, LO, e.lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = OP_NONE; A = '0; B = '0; md_use_D = 1'b0;
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_neg1", OP_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mult_neg3", OP_MULT,  32'hFFFF_FFFD, 32'd4, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_op("multu_carry", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000);
    run_op("div_m7_2", OP_DIV,  32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_7_m2", OP_DIV,  32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("div_m7_m2", OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'd3);
    run_op("div_wrap", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 10, 32'hF, 32'h0FFF_FFFF);
    run_op("mthi", OP_MTHI, 32'h12, 32'd0, 0, 32'h12, 32'h0FFF_FFFF);
    run_op("mtlo", OP_MTLO, 32'h34, 32'd0, 0, 32'h12, 32'h34);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, 10, 32'h12, 32'h34);
    run_op("op_none", OP_NONE, 32'hDEAD_BEEF, 32'd3, 0, 32'h12, 32'h34);

    // Stall window, and an mthi issued mid-operation must not reach HI.
    @(negedge clk);
    md_use_D = 1'b1;
    start    = 1'b1;
    mdu_op   = OP_MTHI;
    A        = 32'h77;
    #1;
    chk("stall_mthi_start", 32'(stall), 32'd0);
    mdu_op = OP_MULT;
    A      = 32'hFFFF_FFFF;
    B      = 32'd6;
    #1;
    chk("stall_mult_start", 32'(stall), 32'd1);
    @(posedge clk); #1;
    start  = 1'b0;
    mdu_op = OP_NONE;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_busy%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("stall_busy%0d_stall", i), 32'(stall), 32'd1);
      if (i == 1) begin
        start  = 1'b1;
        mdu_op = OP_MTHI;
        A      = 32'h55;
      end
      @(posedge clk); #1;
      start  = 1'b0;
      mdu_op = OP_NONE;
      if (i == 1) chk("mthi_while_busy_hi", HI, 32'h12);
    end
    chk("stall_done_busy", 32'(busy), 32'd0);
    chk("stall_done_stall", 32'(stall), 32'd0);
    chk("stall_mult_hi", HI, 32'hFFFF_FFFF);
    chk("stall_mult_lo", LO, 32'hFFFF_FFFA);
    md_use_D = 1'b0;

    // Asynchronous reset during the third busy cycle.
    @(negedge clk);
    start  = 1'b1;
    mdu_op = OP_MULT;
    A      = 32'd7;
    B      = 32'd9;
    @(posedge clk); #1;
    start  = 1'b0;
    mdu_op = OP_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_hi", HI, 32'd0);
    chk("async_reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mtlo_after_reset", OP_MTLO, 32'h99, 32'd0, 0, 32'd0, 32'h99);

`ifdef MDU_MADD_EN
    run_op("madd_setup", OP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
    run_op("madd_carry", OP_RSV, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    run_op("madd_neg", OP_RSV, 32'hFFFF_FFFF, 32'd2, 5, 32'd0, 32'hFFFF_FFFE);
`else
    run_op("reserved_op", OP_RSV, 32'hFFFF_FFFF, 32'd2, 0, 32'd0, 32'h99);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
